// File: rtl/ioshim_ep_fifo.sv
// ioshim_ep_fifo: byte-stream endpoint on the ioshim_cpu io bus.
// Four endpoint slots serve a CPU-to-sink TX FIFO and a source-to-CPU RX FIFO.
module ioshim_ep_fifo #(
    parameter int EPBASE = 4,
    parameter int DEPTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        io_en,
    input  logic [4:0]  io_epnum,
    input  logic [7:0]  io_dout1,
    input  logic [7:0]  io_dout2,
    input  logic [15:0] io_ab_dout,
    output logic        io_wreg,
    output logic [7:0]  io_din,
    output logic        io_wa,
    output logic        io_wb,
    output logic [15:0] io_ab_din,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0] EPB = 5'(EPBASE);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_rp_q, tx_wp_q, rx_rp_q, rx_wp_q;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;

    logic          wreg_q, wa_q, wb_q, wreg_d, wa_d, wb_d;
    logic [7:0]    din_q, din_d;
    logic [15:0]   ab_q, ab_d;

    logic          hit, tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
    logic [1:0]    k;
    logic [7:0]    rx_head;

    // A/B operand is not used by this endpoint
    logic          unused_ab;
    assign unused_ab = ^io_ab_dout;

    assign hit      = io_en && (io_epnum[4:2] == EPB[4:2]);
    assign k        = io_epnum[1:0];
    assign tx_full  = (tx_cnt_q == FULLC);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULLC);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem_q[tx_rp_q];
    assign rx_ready = !rx_full && resetn;
    assign rx_head  = rx_mem_q[rx_rp_q];

    assign tx_push  = hit && (k == 2'd0) && !tx_full;
    assign rx_pop   = hit && (k == 2'd1) && !rx_empty;
    assign tx_flush = hit && (k == 2'd3) && io_dout1[0];
    assign rx_flush = hit && (k == 2'd3) && io_dout1[1];
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid && rx_ready;

    assign io_wreg   = wreg_q;
    assign io_din    = din_q;
    assign io_wa     = wa_q;
    assign io_wb     = wb_q;
    assign io_ab_din = ab_q;

    // Count update; a flush wins over any same-cycle push or pop
    always_comb begin
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (tx_flush) tx_cnt_d = '0;
        if (rx_flush) rx_cnt_d = '0;
    end

    // Response decode for the request sampled this cycle
    always_comb begin
        wreg_d = 1'b0;
        din_d  = 8'h00;
        wa_d   = 1'b0;
        wb_d   = 1'b0;
        ab_d   = 16'h0000;
        if (hit) begin
            unique case (k)
                2'd0: begin
                    wreg_d = 1'b1;
                    din_d  = {7'b0, tx_push};
                end
                2'd1: begin
                    wreg_d = 1'b1;
                    din_d  = rx_empty ? 8'h00 : rx_head;
                    wa_d   = 1'b1;
                    ab_d   = {15'b0, !rx_empty};
                end
                2'd2: begin
                    wreg_d = 1'b1;
                    din_d  = {6'b0, tx_full, rx_empty};
                    wb_d   = 1'b1;
                    ab_d   = {8'(tx_cnt_q), 8'(rx_cnt_q)};
                end
                2'd3: begin
                    wreg_d = 1'b0;
                end
            endcase
        end
    end

    // FIFO storage writes; data array needs no reset
    always_ff @(posedge clk) begin
        if (tx_push && !tx_flush) tx_mem_q[tx_wp_q] <= io_dout2;
        if (rx_push && !rx_flush) rx_mem_q[rx_wp_q] <= rx_data;
    end

    // Pointers, counts and registered response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_rp_q  <= '0;
            tx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_wp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            wreg_q   <= 1'b0;
            din_q    <= 8'h00;
            wa_q     <= 1'b0;
            wb_q     <= 1'b0;
            ab_q     <= 16'h0000;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (tx_flush) begin
                tx_rp_q <= '0;
                tx_wp_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
                if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            end
            if (rx_flush) begin
                rx_rp_q <= '0;
                rx_wp_q <= '0;
            end else begin
                if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
                if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            end
            wreg_q <= wreg_d;
            din_q  <= din_d;
            wa_q   <= wa_d;
            wb_q   <= wb_d;
            ab_q   <= ab_d;
        end
    end

endmodule
